pipe_sel_mux: RTL and testbench

- Parametrised N-way operand selector with a pipeline register; successor to the 2/4-way combinational datapath muxes.
- Picks one of NUM_SRC DATA_W-bit sources by one-hot select, with fixed priority resolution.
- Registers the result into a stage register with stall (hold) and flush (bubble) control.
- Sits at the ID/EX boundary of the pipelined CPU for forwarding-path operand selection: register file, EX/MEM result, MEM/WB result, immediate, etc.

---
 rtl/pipe_sel_mux_if.sv | 26 ++
 rtl/pipe_sel_mux.sv | 93 +++++++++
 tb/tb_pipe_sel_mux.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pipe_sel_mux_if.sv
// Operand-select stage bus: source operands and controls in, registered stage outputs back.
interface pipe_sel_mux_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC*DATA_W-1:0] in_data;
    logic [NUM_SRC-1:0]        in_sel;
    logic                      in_valid;
    logic                      stall;
    logic                      flush;
    logic [DATA_W-1:0]         out_data;
    logic [2:0]                out_src;
    logic                      out_valid;
    logic                      out_nosel;
    logic                      err_multi;

    modport master (
        output in_data, in_sel, in_valid, stall, flush,
        input  out_data, out_src, out_valid, out_nosel, err_multi
    );

    modport slave (
        input  in_data, in_sel, in_valid, stall, flush,
        output out_data, out_src, out_valid, out_nosel, err_multi
    );
endinterface

// File: rtl/pipe_sel_mux.sv
// N-way priority operand selector with a stall/flush stage register at the ID/EX boundary.
// Define PIPE_SEL_MUX_ONEHOT_CHK_EN to build the sticky multi-select checker (err_multi).
module pipe_sel_mux #(
    parameter int                 DATA_W  = 32,
    parameter int                 NUM_SRC = 4,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_sel_mux_if.slave bus
);
    logic [DATA_W-1:0] sel_data;
    logic [2:0]        sel_idx;
    logic              sel_none;

    logic [DATA_W-1:0] data_d,  data_q;
    logic [2:0]        src_d,   src_q;
    logic              valid_d, valid_q;
    logic              nosel_d, nosel_q;
    logic              load;

    // Walk from the top index down so the lowest set bit is the last one to win.
    always_comb begin
        sel_data = bus.in_data[DATA_W-1:0];
        sel_idx  = 3'd0;
        sel_none = 1'b1;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (bus.in_sel[i]) begin
                sel_data = bus.in_data[i*DATA_W +: DATA_W];
                sel_idx  = 3'(i);
                sel_none = 1'b0;
            end
        end
    end

    assign load = !bus.flush && !bus.stall;

    always_comb begin
        data_d  = data_q;
        src_d   = src_q;
        valid_d = valid_q;
        nosel_d = nosel_q;
        if (bus.flush) begin
            data_d  = RST_VAL;
            src_d   = 3'd0;
            valid_d = 1'b0;
            nosel_d = 1'b0;
        end else if (!bus.stall) begin
            data_d  = sel_data;
            src_d   = sel_idx;
            valid_d = bus.in_valid;
            nosel_d = sel_none & bus.in_valid;
        end
    end

`ifdef PIPE_SEL_MUX_ONEHOT_CHK_EN
    logic err_d, err_q;
    logic multi_hot;

    assign multi_hot = ($countones(bus.in_sel) > 1);
    // Sticky until reset; flush and stall cannot clear it.
    assign err_d     = err_q | (load & bus.in_valid & multi_hot);
    assign bus.err_multi = err_q;
`else
    assign bus.err_multi = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= RST_VAL;
            src_q   <= 3'd0;
            valid_q <= 1'b0;
            nosel_q <= 1'b0;
`ifdef PIPE_SEL_MUX_ONEHOT_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            data_q  <= data_d;
            src_q   <= src_d;
            valid_q <= valid_d;
            nosel_q <= nosel_d;
`ifdef PIPE_SEL_MUX_ONEHOT_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;
    assign bus.out_valid = valid_q;
    assign bus.out_nosel = nosel_q;

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Directed plus randomized bench for pipe_sel_mux against a lowest-set-bit reference model.
module tb_pipe_sel_mux;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    localparam logic [127:0] DPAT = {32'h33, 32'h22, 32'h11, 32'h00};

    pipe_sel_mux_if #(.DATA_W(32), .NUM_SRC(4)) bus4 ();
    pipe_sel_mux_if #(.DATA_W(8),  .NUM_SRC(8)) bus8 ();

    pipe_sel_mux #(.DATA_W(32), .NUM_SRC(4), .RST_VAL(32'h0)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    pipe_sel_mux #(.DATA_W(8), .NUM_SRC(8), .RST_VAL(8'h0)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_data;
    logic [2:0]  m_src;
    logic        m_valid, m_nosel, m_err;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_data = 32'h0; m_src = 3'd0; m_valid = 1'b0; m_nosel = 1'b0; m_err = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"},  64'(bus4.out_data),  64'(m_data));
        chk({tag, ".src"},   64'(bus4.out_src),   64'(m_src));
        chk({tag, ".valid"}, 64'(bus4.out_valid), 64'(m_valid));
        chk({tag, ".nosel"}, 64'(bus4.out_nosel), 64'(m_nosel));
        chk({tag, ".err"},   64'(bus4.err_multi), 64'(m_err));
    endtask

    // Reference: isolate lowest set bit arithmetically, take its log2 as the index.
    task automatic step(input string tag, input bit fl, input bit st, input bit v,
                        input logic [3:0] sel, input logic [127:0] d);
        logic [3:0] iso;
        int k;
        bus4.flush = fl; bus4.stall = st; bus4.in_valid = v;
        bus4.in_sel = sel; bus4.in_data = d;
        @(posedge clk);
        if (fl) begin
            m_data = 32'h0; m_src = 3'd0; m_valid = 1'b0; m_nosel = 1'b0;
        end else if (!st) begin
            iso = sel & (~sel + 4'd1);
            k = (sel == 4'd0) ? 0 : $clog2(iso);
            m_data  = 32'(d >> (32 * k));
            m_src   = 3'(k);
            m_valid = v;
            m_nosel = v && (sel == 4'd0);
`ifdef PIPE_SEL_MUX_ONEHOT_CHK_EN
            if (v && ($countones(sel) > 1)) m_err = 1'b1;
`endif
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        bit exp_err;
        rst_n = 1'b0;
        bus4.flush = 0; bus4.stall = 0; bus4.in_valid = 0; bus4.in_sel = '0; bus4.in_data = '0;
        bus8.flush = 0; bus8.stall = 0; bus8.in_valid = 0; bus8.in_sel = '0; bus8.in_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset8.data", 64'(bus8.out_data), 64'h0);
        rst_n = 1'b1;

        // Basic select, then priority and no-select.
        step("basic", 0, 0, 1, 4'b0100, DPAT);
        chk("basic.data_const", 64'(bus4.out_data), 64'h22);
        chk("basic.src_const",  64'(bus4.out_src),  64'd2);
        step("prio", 0, 0, 1, 4'b1010, DPAT);
        chk("prio.data_const", 64'(bus4.out_data), 64'h11);
`ifdef PIPE_SEL_MUX_ONEHOT_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        chk("prio.err_const", 64'(bus4.err_multi), 64'(exp_err));
        step("nosel", 0, 0, 1, 4'b0000, DPAT);
        chk("nosel.flag_const", 64'(bus4.out_nosel), 64'd1);
        step("invalid_load", 0, 0, 0, 4'b0000, DPAT);

        // Mid-cycle async reset: outputs clear before the next edge.
        step("pre_rst", 0, 0, 1, 4'b1000, DPAT);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst8.src", 64'(bus8.out_src), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stall holds across three cycles while inputs change.
        step("stall_load", 0, 0, 1, 4'b1000, DPAT);
        for (int i = 0; i < 3; i++) begin
            step("stall_hold", 0, 1, 1, 4'b0001, DPAT);
            chk("stall.data_const", 64'(bus4.out_data), 64'h33);
            chk("stall.src_const",  64'(bus4.out_src),  64'd3);
        end
        step("stall_release", 0, 0, 1, 4'b0001, DPAT);
        chk("stall_release.data_const", 64'(bus4.out_data), 64'h00);

        // Flush beats stall.
        step("flush_stall", 1, 1, 1, 4'b0100, DPAT);
        chk("flush_stall.valid_const", 64'(bus4.out_valid), 64'd0);
        step("post_flush", 0, 0, 1, 4'b0010, DPAT);
        chk("post_flush.data_const", 64'(bus4.out_data), 64'h11);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step("rand",
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)),
                 {$urandom, $urandom, $urandom, $urandom});
        end

        // Reset during stall wins immediately, and clears the sticky flag.
        step("pre_rst_stall", 0, 1, 1, 4'b0110, DPAT);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_in_stall");
        @(negedge clk);
        rst_n = 1'b1;
        bus4.stall = 1'b0;

        // Eight 8-bit sources.
        bus8.in_sel = 8'h80; bus8.in_valid = 1'b1;
        bus8.in_data = {8'hA5, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
        @(posedge clk); #1;
        chk("p8.data",  64'(bus8.out_data),  64'hA5);
        chk("p8.src",   64'(bus8.out_src),   64'd7);
        chk("p8.valid", 64'(bus8.out_valid), 64'd1);
        bus8.in_sel = 8'h24;
        @(posedge clk); #1;
        chk("p8.prio_data", 64'(bus8.out_data), 64'h22);
        chk("p8.prio_src",  64'(bus8.out_src),  64'd2);
        bus8.in_sel = 8'h00;
        @(posedge clk); #1;
        chk("p8.nosel",      64'(bus8.out_nosel), 64'd1);
        chk("p8.nosel_data", 64'(bus8.out_data),  64'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
